dosing_sequencer: RTL and testbench

Parametrised motor-dosing timer that runs N_CH dispenser motors, each for a programmed number of dose units, either one after another or all at once. It takes over from the fixed three-channel R/G/B timer: it sits between the RGB dose memory and the top-level FSM, and accepts per-channel dose counts directly from the dose registers. It adds a selectable mode, pause, abort and per-channel completion flags, and derives its own dose-unit tick from the system clock.

---
 rtl/dosing_pkg.sv | 15 +
 rtl/dose_channel.sv | 42 ++++
 rtl/dosing_sequencer.sv | 178 +++++++++++++++++
 tb/tb_dosing_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dosing_pkg.sv
// Shared types for the dosing sequencer.
// FSM state encoding and operating-mode constants.
package dosing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN_SEQ,
        RUN_PAR,
        FINISH
    } state_e;

    localparam logic MODE_SEQ = 1'b0;
    localparam logic MODE_PAR = 1'b1;

endpackage

// File: rtl/dose_channel.sv
// Remaining-dose-units counter for one dispenser channel.
// Ports: load/load_val reload the count; tick+active decrement it;
// zero flags an empty count, last flags exactly one unit left.
module dose_channel
    import dosing_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    input  logic             active,
    output logic             zero,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && active && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/dosing_sequencer.sv
// Motor-dosing timer: runs N_CH motors for programmed dose units,
// sequentially or in parallel, with pause, abort and done flags.
module dosing_sequencer
    import dosing_pkg::*;
#(
    parameter int N_CH     = 3,
    parameter int CNT_W    = 5,
    parameter int TICK_DIV = 5_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  mode,
    input  logic [N_CH*CNT_W-1:0] dose,
    output logic [N_CH-1:0]       motor,
    output logic [N_CH-1:0]       done,
    output logic                  busy,
    output logic                  finished,
    output logic                  aborted
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [N_CH-1:0]   motor_q, motor_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic              aborted_q, aborted_d;

    logic              run;
    logic              tick;
    logic              load;
    logic [N_CH-1:0]   act;
    logic [N_CH-1:0]   zero;
    logic [N_CH-1:0]   last;
    logic [N_CH-1:0]   ex;
    logic [N_CH-1:0]   zero_after;
    logic [N_CH-1:0]   dz;
    logic [PTR_W-1:0]  first;
    logic [PTR_W-1:0]  nxt;
    logic              nxt_vld;

    assign run  = (state_q == RUN_SEQ) || (state_q == RUN_PAR);
    assign tick = run && !pause && !abort &&
                  (presc_q == PRE_W'(TICK_DIV - 1));

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign act[g] = (state_q == RUN_PAR) ||
                        ((state_q == RUN_SEQ) && (ptr_q == PTR_W'(g)));

        dose_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .load_val (dose[g*CNT_W +: CNT_W]),
            .tick     (tick),
            .active   (act[g]),
            .zero     (zero[g]),
            .last     (last[g])
        );
    end

    // A channel exhausts on the tick that consumes its final unit.
    assign ex         = act & last & {N_CH{tick}};
    assign zero_after = zero | ex;

    // Lowest nonzero channel at start, and the lowest still-loaded
    // channel above the current pointer for sequential handover.
    always_comb begin
        dz      = '0;
        first   = '0;
        nxt     = '0;
        nxt_vld = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            dz[i] = (dose[i*CNT_W +: CNT_W] == '0);
            if (!dz[i]) begin
                first = PTR_W'(i);
            end
            if ((i > int'(ptr_q)) && !zero[i]) begin
                nxt     = PTR_W'(i);
                nxt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ptr_d     = ptr_q;
        motor_d   = motor_q;
        done_d    = done_q;
        aborted_d = 1'b0;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                motor_d = '0;
                if (start) begin
                    load    = 1'b1;
                    presc_d = '0;
                    done_d  = dz;
                    ptr_d   = first;
                    if (mode == MODE_PAR) begin
                        state_d = RUN_PAR;
                        motor_d = ~dz;
                    end else begin
                        state_d = RUN_SEQ;
                        for (int i = 0; i < N_CH; i++) begin
                            motor_d[i] = (first == PTR_W'(i)) && !dz[i];
                        end
                    end
                end
            end
            RUN_SEQ, RUN_PAR: begin
                if (abort) begin
                    state_d   = IDLE;
                    motor_d   = '0;
                    aborted_d = 1'b1;
                end else if (pause) begin
                    motor_d = '0;
                end else begin
                    presc_d = tick ? '0 : presc_q + PRE_W'(1);
                    done_d  = done_q | ex;
                    if ((state_q == RUN_SEQ) && (ex != '0) && nxt_vld) begin
                        ptr_d = nxt;
                    end
                    for (int i = 0; i < N_CH; i++) begin
                        if (state_q == RUN_PAR) begin
                            motor_d[i] = !zero_after[i];
                        end else begin
                            motor_d[i] = (ptr_d == PTR_W'(i)) &&
                                         !zero_after[i];
                        end
                    end
                    if (&zero_after) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                motor_d = '0;
            end
            default: begin
                state_d = IDLE;
                motor_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ptr_q     <= '0;
            motor_q   <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ptr_q     <= ptr_d;
            motor_q   <= motor_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign motor    = motor_q;
    assign done     = done_q;
    assign busy     = run;
    assign finished = (state_q == FINISH);
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_dosing_sequencer.sv
// Self-checking bench for dosing_sequencer (N_CH=3, CNT_W=5, TICK_DIV=4).
// Reference model tracks remaining motor-on cycles per channel.
module tb_dosing_sequencer;

    localparam int N  = 3;
    localparam int W  = 5;
    localparam int TD = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           pause = 1'b0;
    logic           mode = 1'b0;
    logic [N*W-1:0] dose = '0;
    logic [N-1:0]   motor;
    logic [N-1:0]   done;
    logic           busy;
    logic           finished;
    logic           aborted;

    dosing_sequencer #(.N_CH(N), .CNT_W(W), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .pause    (pause),
        .mode     (mode),
        .dose     (dose),
        .motor    (motor),
        .done     (done),
        .busy     (busy),
        .finished (finished),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // reference model
    bit         m_run, m_fin, m_pz, m_ab, m_par;
    int         m_rem[N];
    logic [N-1:0] m_done;

    // directed-test bookkeeping
    int hi[N];
    int cyc_n, last_hi, fin_at, fin_cnt;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_fin = 0; m_pz = 0; m_ab = 0; m_par = 0;
        m_done = '0;
        for (int i = 0; i < N; i++) m_rem[i] = 0;
    endtask

    function automatic logic [N-1:0] m_motor();
        logic [N-1:0] m;
        bit taken;
        m = '0;
        taken = 0;
        if (m_run && !m_pz) begin
            for (int i = 0; i < N; i++) begin
                if (m_rem[i] > 0) begin
                    if (m_par) m[i] = 1'b1;
                    else if (!taken) begin m[i] = 1'b1; taken = 1; end
                end
            end
        end
        return m;
    endfunction

    // One clock edge of the reference, from the inputs sampled at it.
    task automatic model_step();
        bit any;
        bit taken;
        m_ab = 0;
        if (m_fin) begin
            m_fin = 0;
        end else if (!m_run) begin
            if (start) begin
                m_run = 1; m_pz = 0; m_par = mode;
                for (int i = 0; i < N; i++) begin
                    m_rem[i]  = int'(dose[i*W +: W]) * TD;
                    m_done[i] = (m_rem[i] == 0);
                end
            end
        end else if (abort) begin
            m_run = 0; m_ab = 1;
        end else if (pause) begin
            m_pz = 1;
        end else begin
            m_pz = 0;
            taken = 0;
            for (int i = 0; i < N; i++) begin
                if (m_rem[i] > 0 && (m_par || !taken)) begin
                    taken = 1;
                    m_rem[i]--;
                    if (m_rem[i] == 0) m_done[i] = 1'b1;
                end
            end
            any = 0;
            for (int i = 0; i < N; i++) if (m_rem[i] > 0) any = 1;
            if (!any) begin m_run = 0; m_fin = 1; end
        end
    endtask

    task automatic check_outs();
        check("motor", 32'(motor), 32'(m_motor()));
        check("done", 32'(done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_run));
        check("finished", 32'(finished), 32'(m_fin));
        check("aborted", 32'(aborted), 32'(m_ab));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_outs();
        cyc_n++;
        for (int i = 0; i < N; i++) hi[i] += int'(motor[i]);
        if (motor != '0) last_hi = cyc_n;
        if (finished) begin fin_at = cyc_n; fin_cnt++; end
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) hi[i] = 0;
        cyc_n = 0; last_hi = -1; fin_at = -1; fin_cnt = 0;
    endtask

    task automatic launch(logic md, logic [W-1:0] d2, logic [W-1:0] d1,
                          logic [W-1:0] d0);
        @(negedge clk);
        mode  = md;
        dose  = {d2, d1, d0};
        start = 1'b1;
        clr();
        cyc();
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        model_reset();
        clr();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", 32'({motor, done, busy, finished, aborted}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // sequential {B=1,G=0,R=2}
        launch(1'b0, 5'd1, 5'd0, 5'd2);
        check("seq_lat", 32'(motor), 32'd1);
        repeat (16) cyc();
        check("seq_hi0", 32'(hi[0]), 32'd8);
        check("seq_hi1", 32'(hi[1]), 32'd0);
        check("seq_hi2", 32'(hi[2]), 32'd4);
        check("seq_done", 32'(done), 32'b111);
        check("seq_fin", 32'(fin_at), 32'(last_hi + 1));

        // parallel {3,1,2}
        launch(1'b1, 5'd3, 5'd1, 5'd2);
        check("par_lat", 32'(motor), 32'b111);
        repeat (15) cyc();
        check("par_hi0", 32'(hi[0]), 32'd8);
        check("par_hi1", 32'(hi[1]), 32'd4);
        check("par_hi2", 32'(hi[2]), 32'd12);
        check("par_fin", 32'(fin_at), 32'd13);

        // pause during a 2-unit channel
        launch(1'b0, 5'd0, 5'd0, 5'd2);
        repeat (2) cyc();
        @(negedge clk);
        pause = 1'b1;
        repeat (10) cyc();
        @(negedge clk);
        pause = 1'b0;
        repeat (20) cyc();
        check("pause_hi", 32'(hi[0]), 32'd8);

        // abort after 5 cycles of {1,1,1}
        launch(1'b0, 5'd1, 5'd1, 5'd1);
        repeat (4) cyc();
        @(negedge clk);
        abort = 1'b1;
        cyc();
        @(negedge clk);
        abort = 1'b0;
        check("abort_pulse", 32'(aborted), 32'd1);
        check("abort_done", 32'(done), 32'b001);
        check("abort_motor", 32'(motor), 32'd0);
        repeat (5) cyc();
        check("abort_nofin", 32'(fin_cnt), 32'd0);
        launch(1'b0, 5'd1, 5'd1, 5'd1);
        check("abort_clr", 32'(done), 32'd0);
        repeat (14) cyc();

        // all-zero batch
        launch(1'b0, 5'd0, 5'd0, 5'd0);
        cyc();
        check("zero_fin", 32'(finished), 32'd1);
        check("zero_done", 32'(done), 32'b111);
        repeat (2) cyc();
        check("zero_hi", 32'(hi[0] + hi[1] + hi[2]), 32'd0);

        // maximum dose
        launch(1'b1, 5'd0, 5'd31, 5'd0);
        repeat (130) cyc();
        check("max_hi", 32'(hi[1]), 32'd124);

        // async reset mid parallel run
        launch(1'b1, 5'd5, 5'd5, 5'd5);
        repeat (6) cyc();
        @(posedge clk);
        model_step();
        #3;
        reset = 1'b0;
        #1;
        check("arst_motor", 32'(motor), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outs();
        end
        @(negedge clk);
        reset = 1'b1;
        launch(1'b0, 5'd1, 5'd0, 5'd1);
        repeat (12) cyc();
        check("arst_after", 32'(hi[0] + hi[2]), 32'd8);

        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            abort = ($urandom % 50) == 0;
            pause = ($urandom % 8) == 0;
            mode  = 1'($urandom % 2);
            for (int i = 0; i < N; i++) begin
                dose[i*W +: W] = W'($urandom_range(0, 3));
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
